// File: rtl/ps2kbd_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ps2kbd_rx_fifo
// Purpose  : PS/2 keyboard receiver. Synchronizes the keyboard clock/data,
//            assembles 11-bit frames, checks start/stop/odd parity and
//            queues valid scan codes in a small FIFO for the consumer.
// Revision : 1.0 - initial release
// ============================================================================
module ps2kbd_rx_fifo #(
  parameter int          DEPTH   = 8,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int               c_aw      = $clog2(DEPTH);
  localparam logic [c_aw:0]    c_full    = DEPTH[c_aw:0];
  localparam logic [c_aw-1:0]  c_ptr_one = c_aw'(1);
  localparam logic [c_aw:0]    c_cnt_one = (c_aw + 1)'(1);

  // Synchronizer, edge-history and frame assembly state
  logic            r_clk_s1, r_clk_s2, r_clk_hist;
  logic            r_dat_s1, r_dat_s2;
  logic [10:0]     r_frame;
  logic [3:0]      r_bit_cnt;
  logic            r_done;
  logic [15:0]     r_to_cnt;

  // FIFO state
  logic [7:0]      r_mem [DEPTH];
  logic [c_aw-1:0] r_wptr, r_rptr;
  logic [c_aw:0]   r_count;
  logic            r_overflow;

  logic            w_fall;
  logic            w_valid;
  logic            w_push_req;
  logic            w_full;
  logic            w_pop;
  logic            w_push;

  assign w_fall     = r_clk_hist & ~r_clk_s2;
  // Frame held in r_frame is complete during the cycle r_done is high
  assign w_valid    = ~r_frame[0] & r_frame[10] & (^r_frame[9:1]);
  assign w_push_req = r_done & w_valid;
  assign w_full     = (r_count == c_full);
  assign ready      = (r_count != '0);
  assign w_pop      = ~nextdata_n & ready;
  // A full FIFO still accepts a frame when the same cycle frees a slot
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign frame_err  = r_done & ~w_valid;
  assign overflow   = r_overflow;
  assign data       = r_mem[r_rptr];

  // Two-flop synchronizers plus clock history; idle level of the bus is 1
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_hist <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_hist <= r_clk_s2;
      r_dat_s1   <= ps2_data;
      r_dat_s2   <= r_dat_s1;
    end
  end

  // Shift bits LSB first on each falling edge; abandon stalled partial frames
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame   <= '0;
      r_bit_cnt <= '0;
      r_done    <= 1'b0;
      r_to_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_fall) begin
        r_frame  <= {r_dat_s2, r_frame[10:1]};
        r_to_cnt <= '0;
        if (r_bit_cnt == 4'd10) begin
          r_bit_cnt <= '0;
          r_done    <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
      end else if (r_bit_cnt == '0) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt == TIMEOUT - 16'd1) begin
        r_bit_cnt <= '0;
        r_to_cnt  <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + 16'd1;
      end
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_ptr_one;
      if (w_pop)  r_rptr <= r_rptr + c_ptr_one;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
      if (w_push_req && !w_push) r_overflow <= 1'b1;
    end
  end

  // FIFO storage; contents need no reset since ready gates their use
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= r_frame[8:1];
  end

endmodule
`default_nettype wire
